// File: rtl/dht11_pkg.sv
// Shared types and helpers for the DHT11 read scheduler.
// The DHT11_AUTO_PERIOD_EN option lives in the top-level file.
package dht11_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GAP,
        ST_START,
        ST_WAIT,
        ST_CHECK,
        ST_PUBLISH,
        ST_FAIL_ATTEMPT
    } state_t;

    localparam int RH_INT_LSB = 32;
    localparam int RH_DEC_LSB = 24;
    localparam int T_INT_LSB  = 16;
    localparam int T_DEC_LSB  = 8;
    localparam int CSUM_LSB   = 0;

    // Bits needed to hold values 0..max_val; never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    // The sum is kept 10 bits wide, but only its low byte is compared with the checksum.
    function automatic logic checksum_ok(input logic [39:0] frame);
        logic [9:0] sum;
        sum = {2'b00, frame[RH_INT_LSB +: 8]} + {2'b00, frame[RH_DEC_LSB +: 8]}
            + {2'b00, frame[T_INT_LSB +: 8]}  + {2'b00, frame[T_DEC_LSB +: 8]};
        return sum[7:0] == frame[CSUM_LSB +: 8];
    endfunction

endpackage

// File: rtl/dht11_read_scheduler_ms_tick.sv
// Free-running millisecond strobe: one-cycle pulse every CLK_HZ/1000 clocks.
module dht11_ms_tick
    import dht11_pkg::*;
#(
    parameter int CLK_HZ = 100000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int DIV = CLK_HZ / 1000;
    localparam int CW  = cnt_width(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (cnt == CW'(DIV - 1))
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    assign tick = (cnt == CW'(DIV - 1));

endmodule

// File: rtl/dht11_read_scheduler.sv
// DHT11 read scheduler: gap/timeout sequencing, checksum validation and retries.
// Define DHT11_AUTO_PERIOD_EN to add periodic self-triggered reads.
module dht11_read_scheduler
    import dht11_pkg::*;
#(
    parameter int CLK_HZ     = 100000,
    parameter int MIN_GAP_MS = 1000,
    parameter int TIMEOUT_MS = 50,
    parameter int MAX_RETRY  = 3,
    parameter int PERIOD_MS  = 2000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        req,
    output logic        busy,
    output logic        rd_start,
    input  logic        rd_done,
    input  logic [39:0] rd_data,
    output logic [15:0] humidity,
    output logic [15:0] temperature,
    output logic        sample_valid,
    output logic        err_checksum,
    output logic        err_timeout,
    output logic [2:0]  retry_cnt
);

    localparam int         GW        = cnt_width(MIN_GAP_MS);
    localparam int         TW        = cnt_width(TIMEOUT_MS);
    localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRY);

    state_t        state, next_state;
    logic          tick;
    logic [GW-1:0] gap_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          pending;
    logic          auto_fire;
    logic [2:0]    attempt;
    logic          fail_timeout;
    logic [39:0]   frame;
    logic          tmo_expire;
    logic          frame_ok;
    logic          retry_left;

    dht11_ms_tick #(.CLK_HZ(CLK_HZ)) u_ms_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Expiry is the tick that would take the counter to zero, so rd_done in that cycle still wins.
    assign tmo_expire = (tmo_cnt == '0) || (tick && (tmo_cnt == TW'(1)));
    assign frame_ok   = checksum_ok(frame);
    assign retry_left = (attempt < RETRY_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state   = state;
        busy         = (state != ST_IDLE);
        rd_start     = 1'b0;
        sample_valid = 1'b0;
        case (state)
            ST_IDLE:         if (pending) next_state = ST_GAP;
            ST_GAP:          if (gap_cnt == '0) next_state = ST_START;
            ST_START: begin
                rd_start   = 1'b1;
                next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (rd_done)
                    next_state = ST_CHECK;
                else if (tmo_expire)
                    next_state = ST_FAIL_ATTEMPT;
            end
            ST_CHECK:        next_state = frame_ok ? ST_PUBLISH : ST_FAIL_ATTEMPT;
            ST_PUBLISH: begin
                sample_valid = 1'b1;
                next_state   = ST_IDLE;
            end
            ST_FAIL_ATTEMPT: next_state = retry_left ? ST_GAP : ST_IDLE;
            default:         next_state = ST_IDLE;
        endcase
    end

    // The gap counter starts loaded so the sensor gets its power-up hold-off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_cnt <= GW'(MIN_GAP_MS);
            tmo_cnt <= '0;
        end else begin
            if (state == ST_START)
                gap_cnt <= GW'(MIN_GAP_MS);
            else if (tick && (gap_cnt != '0))
                gap_cnt <= gap_cnt - GW'(1);

            if (state == ST_START)
                tmo_cnt <= TW'(TIMEOUT_MS);
            else if ((state == ST_WAIT) && tick && (tmo_cnt != '0))
                tmo_cnt <= tmo_cnt - TW'(1);
        end
    end

    // Only the first attempt consumes pending, so requests made during a retry are kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pending <= 1'b0;
        else if ((req && enable) || auto_fire)
            pending <= 1'b1;
        else if ((state == ST_GAP) && (next_state == ST_START) && (attempt == 3'd0))
            pending <= 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            attempt      <= '0;
            fail_timeout <= 1'b0;
            frame        <= '0;
        end else begin
            if (state == ST_IDLE)
                attempt <= '0;
            else if ((state == ST_FAIL_ATTEMPT) && retry_left)
                attempt <= attempt + 3'd1;

            if ((state == ST_WAIT) && rd_done)
                frame <= rd_data;

            if ((state == ST_WAIT) && (next_state == ST_FAIL_ATTEMPT))
                fail_timeout <= 1'b1;
            else if ((state == ST_CHECK) && !frame_ok)
                fail_timeout <= 1'b0;
        end
    end

    // Results are loaded on entry to PUBLISH so they are already valid alongside sample_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            humidity     <= '0;
            temperature  <= '0;
            err_checksum <= 1'b0;
            err_timeout  <= 1'b0;
            retry_cnt    <= '0;
        end else if ((state == ST_CHECK) && frame_ok) begin
            humidity     <= frame[RH_DEC_LSB +: 16];
            temperature  <= frame[T_DEC_LSB +: 16];
            err_checksum <= 1'b0;
            err_timeout  <= 1'b0;
            retry_cnt    <= attempt;
        end else if ((state == ST_FAIL_ATTEMPT) && !retry_left) begin
            err_checksum <= !fail_timeout;
            err_timeout  <= fail_timeout;
            retry_cnt    <= RETRY_MAX;
        end
    end

`ifdef DHT11_AUTO_PERIOD_EN
    localparam int EFF_PERIOD = (PERIOD_MS > MIN_GAP_MS) ? PERIOD_MS : MIN_GAP_MS;
    localparam int PW         = cnt_width(EFF_PERIOD);

    logic [PW-1:0] period_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            period_cnt <= PW'(EFF_PERIOD);
        else if (tick) begin
            if (period_cnt <= PW'(1))
                period_cnt <= PW'(EFF_PERIOD);
            else
                period_cnt <= period_cnt - PW'(1);
        end
    end

    assign auto_fire = enable && tick && (period_cnt <= PW'(1));
`else
    assign auto_fire = 1'b0;
`endif

endmodule
